// File: rtl/space_invaders_pkg.sv
// Shared types and sprite constants for the space invaders datapath blocks.
// The bullet scheduler derives its default retire height from the sprite constants.
package space_invaders_pkg;

    localparam int BULLET_WIDTH  = 4;
    localparam int BULLET_HEIGHT = 3;
    localparam int BULLET_SCALE  = 10;
    localparam int BULLET_TRUE_HEIGHT = BULLET_HEIGHT * BULLET_SCALE;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        ALLOC  = 2'd2
    } bullet_sched_state_t;

endpackage

// File: rtl/bullet_sched_lowest_free_slot.sv
// Priority encoder returning the lowest-index slot that is neither live nor being hit.
// Slots hit in the current cycle are excluded so they are never re-allocated the same edge.
module lowest_free_slot #(
    parameter int NUM_BULLETS = 4,
    parameter int IDX_W       = (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1
) (
    input  logic [NUM_BULLETS-1:0] active,
    input  logic [NUM_BULLETS-1:0] hit,
    output logic [IDX_W-1:0]       idx,
    output logic                   any_free
);

    logic [NUM_BULLETS-1:0] free_mask;

    always_comb begin
        free_mask = ~active & ~hit;
        idx       = '0;
        any_free  = 1'b0;
        // Scan high to low so the lowest free index is the last one written.
        for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
            if (free_mask[i]) begin
                idx      = IDX_W'(i);
                any_free = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bullet_sched.sv
// Bullet pool scheduler: per-frame sweep of live bullets, then one cooldown-gated allocation.
// Optional shot counter enabled by defining BULLET_SCHED_STATS_EN.
module bullet_sched
    import space_invaders_pkg::*;
#(
    parameter int SCREEN_CORDW    = 16,
    parameter int NUM_BULLETS     = 4,
    parameter int SPEED           = 4,
    parameter int COOLDOWN_FRAMES = 8,
    parameter int TRUE_HEIGHT     = BULLET_TRUE_HEIGHT
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 frame,
    input  logic                                 fire,
    input  logic signed [SCREEN_CORDW-1:0]       spaceship_x,
    input  logic signed [SCREEN_CORDW-1:0]       spaceship_y,
    input  logic [NUM_BULLETS-1:0]               hit,
    output logic [NUM_BULLETS-1:0]               active,
    output logic [NUM_BULLETS*SCREEN_CORDW-1:0]  bullet_x,
    output logic [NUM_BULLETS*SCREEN_CORDW-1:0]  bullet_y,
    output logic                                 fire_ack,
    output logic [15:0]                          shots_fired
);

    localparam int IDX_W = (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1;
    localparam logic signed [SCREEN_CORDW-1:0] SPEED_S  = SCREEN_CORDW'(SPEED);
    localparam logic [SCREEN_CORDW:0]          HEIGHT_G = (SCREEN_CORDW + 1)'(TRUE_HEIGHT);
    localparam logic [IDX_W-1:0]               LAST_IDX = IDX_W'(NUM_BULLETS - 1);

    bullet_sched_state_t state;
    logic [IDX_W-1:0] idx;
    logic [7:0]       cooldown;
    logic             fire_q;

    logic signed [SCREEN_CORDW-1:0] pos_x [NUM_BULLETS];
    logic signed [SCREEN_CORDW-1:0] pos_y [NUM_BULLETS];

    logic signed [SCREEN_CORDW-1:0] y_new;
    logic [SCREEN_CORDW:0]          y_bottom;
    logic                           retire;
    logic [IDX_W-1:0]               alloc_idx;
    logic                           any_free;
    logic                           alloc_go;
    logic [NUM_BULLETS-1:0]         active_next;

    lowest_free_slot #(
        .NUM_BULLETS (NUM_BULLETS),
        .IDX_W       (IDX_W)
    ) u_free (
        .active   (active),
        .hit      (hit),
        .idx      (alloc_idx),
        .any_free (any_free)
    );

    // One shared subtractor; the bottom edge check carries a guard bit so wrap cannot hide a retire.
    always_comb begin
        y_new    = pos_y[idx] - SPEED_S;
        y_bottom = {y_new[SCREEN_CORDW-1], y_new} + HEIGHT_G;
        retire   = y_bottom[SCREEN_CORDW] || (y_bottom == '0);
        alloc_go = (state == ALLOC) && fire_q && (cooldown == 8'd0) && any_free;
    end

    always_comb begin
        active_next = active;
        if (state == UPDATE && active[idx] && retire)
            active_next[idx] = 1'b0;
        if (alloc_go)
            active_next[alloc_idx] = 1'b1;
        // A collision always has the last word on slot liveness.
        active_next = active_next & ~hit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            cooldown <= 8'd0;
            fire_q   <= 1'b0;
            active   <= '0;
            fire_ack <= 1'b0;
            for (int i = 0; i < NUM_BULLETS; i++) begin
                pos_x[i] <= '0;
                pos_y[i] <= '0;
            end
        end else begin
            fire_ack <= 1'b0;
            active   <= active_next;
            case (state)
                IDLE: begin
                    if (frame) begin
                        fire_q <= fire;
                        if (cooldown != 8'd0)
                            cooldown <= cooldown - 8'd1;
                        idx   <= '0;
                        state <= UPDATE;
                    end
                end
                UPDATE: begin
                    if (active[idx] && !hit[idx])
                        pos_y[idx] <= y_new;
                    if (idx == LAST_IDX)
                        state <= ALLOC;
                    else
                        idx <= idx + IDX_W'(1);
                end
                ALLOC: begin
                    if (alloc_go) begin
                        pos_x[alloc_idx] <= spaceship_x;
                        pos_y[alloc_idx] <= spaceship_y;
                        cooldown         <= 8'(COOLDOWN_FRAMES);
                        fire_ack         <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_BULLETS; g++) begin : g_pack
        assign bullet_x[g*SCREEN_CORDW +: SCREEN_CORDW] = pos_x[g];
        assign bullet_y[g*SCREEN_CORDW +: SCREEN_CORDW] = pos_y[g];
    end

`ifdef BULLET_SCHED_STATS_EN
    logic [15:0] shot_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            shot_count <= 16'd0;
        else if (alloc_go)
            shot_count <= shot_count + 16'd1;
    end

    assign shots_fired = shot_count;
`else
    assign shots_fired = 16'd0;
`endif

endmodule

// File: doc/bullet_sched.md
# bullet_sched

Bullet pool scheduler for the player cannon. Owns up to `NUM_BULLETS` bullet slots and services fire requests under a per-frame cooldown. Once per frame it advances every live bullet, retiring bullets that leave the top of the screen, and frees slots on externally detected hits. It feeds the bullet sprite renderers with per-slot position and enable, and sits between the input/spaceship logic and the collision unit.

## Interface

- `SCREEN_CORDW`, 16: signed screen coordinate width
- `NUM_BULLETS`, 4: slot count, 1..8
- `SPEED`, 4: pixels moved upward per frame
- `COOLDOWN_FRAMES`, 8: minimum frames between accepted shots, 0..255
- `TRUE_HEIGHT`, 30: rendered bullet height in pixels
- `clk  in  1  pixel clock; all logic in this domain`
- `rst  in  1  reset; asynchronous, active-high`
- `frame  in  1  one-cycle pulse at start of frame`
- `fire  in  1  fire button level, sampled on frame`
- `spaceship_x, spaceship_y  in  SCREEN_CORDW each  signed spawn position`
- `hit  in  NUM_BULLETS  per-slot collision pulse`
- `active  out  NUM_BULLETS  slot live; drives sprite enable`
- `bullet_x, bullet_y  out  NUM_BULLETS*SCREEN_CORDW each  packed signed positions, slot i at [i*W +: W]`
- `fire_ack  out  1  one-cycle pulse when a shot is allocated`
- `shots_fired  out  16  accepted-shot count (see Configuration)`

## Operation

- FSM states:
  - `IDLE`: on `frame`, latch `fire` into `fire_q`, decrement `cooldown` if nonzero, clear slot index, go to `UPDATE`.
  - `UPDATE`: one slot per cycle, sharing one subtractor. If `active[i]`, `y_new = y - SPEED`, written back. If `y_new + TRUE_HEIGHT <= 0` (signed, one guard bit), clear `active[i]`. After slot `NUM_BULLETS-1`, go to `ALLOC`.
  - `ALLOC`: allocates if `fire_q && cooldown==0 && ~&active`. Allocation picks the lowest-index free slot, sets x/y to the spaceship coordinates, sets `active`, reloads `cooldown=COOLDOWN_FRAMES`, and pulses `fire_ack`. Go to `IDLE` unconditionally.
- A `frame` arriving outside `IDLE` is ignored. The frame period is always much greater than `NUM_BULLETS+2` cycles.
- `hit[i]` in any cycle clears `active[i]` on the next edge. It wins over an `UPDATE` write-back to the same slot, and over `ALLOC` choosing that slot in the same cycle; that slot is not allocated and allocation moves on to the next free slot.
- Inactive slots keep their last coordinates; consumers must gate on `active`.
- Cooldown 0: a shot is possible every frame, limited only by free slots.

## Timing

- `frame` at cycle t:
  - slot i updates at edge t+1+i
  - `ALLOC` at edge t+NUM_BULLETS+1
  - `fire_ack` high during cycle t+NUM_BULLETS+2
- All outputs are registered.
- `hit` to `active` low: 1 cycle.
- Reset values:
  - `active=0`, all x/y `=0`, `fire_ack=0`, `shots_fired=0`
  - `cooldown=0`, `fire_q=0`, state `IDLE`
- Reset mid-`UPDATE` abandons the sweep. The next `frame` after release starts cleanly.

## Configuration

- `BULLET_SCHED_STATS_EN` defined: `shots_fired` increments on every `fire_ack` and wraps at 16 bits.
- Not defined: no counter flops; `shots_fired` is tied to 0.

## Structure

- Shared package `space_invaders_pkg`:
  - `bullet_sched_state_t` enum (`IDLE`, `UPDATE`, `ALLOC`)
  - bullet sprite constants `BULLET_WIDTH=4`, `BULLET_HEIGHT=3`, `BULLET_SCALE=10`; `TRUE_HEIGHT` defaults from their product
- Sub-module `lowest_free_slot`: combinational priority encoder over `~active & ~hit`, outputting an index and an `any_free` flag.

## Test plan

- Reset, ship (300,40), `fire=1` on one frame pulse at t:
  - `fire_ack` at t+6, `active=4'b0001`, slot0=(300,40).
  - Next frame: slot0 y=36.
- Same shot, no hits: slot0 y reaches 40-4k and is retired on the 18th frame after allocation (y_new=-32). `active` returns to 0.
- `COOLDOWN_FRAMES=8`, `fire` held high: acks on frames 0, 8, 16; none in between. With stats on, `shots_fired=3`.
- `COOLDOWN_FRAMES=0`, `fire` held, ship y=440: acks frames 0–3 fill slots 0–3. Frame 4 gives no ack, `active=4'b1111`.
- Pool full; pulse `hit[1]` for one cycle: `active=4'b1101` next cycle. At the next frame, slot 1 is re-allocated at the ship position with `fire_ack`.
- `hit[2]` coincident with the slot-2 `UPDATE` edge, and `rst` asserted mid-sweep:
  - slot 2 stays inactive
  - after reset all outputs are zero and the following frame sweeps normally.
